// File: rtl/ball_motion_ctrl.sv
// Breakout ball engine: owns ball position, direction, serve/play/dead state
// and the life counter. Presents a probe pixel to the brick map and issues
// brick-clear requests back to it.
//
// state | meaning
// ------+---------------------------------------------
// SERVE | ball rides the paddle, waiting for launch
// PLAY  | ball moving, strobes acted on
// DEAD  | game over, ball frozen until launch
module ball_motion_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_Y    = 440,
    parameter int PADDLE_W    = 64,
    parameter int START_LIVES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       brck_update,
    input  logic       dir_update,
    input  logic       pos_update,
    input  logic       launch,
    input  logic [9:0] paddle_x,
    input  logic       brick_hit,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       brick_clr,
    output logic [9:0] brick_clr_x,
    output logic [9:0] brick_clr_y,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DEAD  = 2'd2
    } state_t;

    localparam logic [10:0] SCR_W11   = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H11   = 11'(SCREEN_H);
    localparam logic [10:0] BALL11    = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_Y11   = 11'(PADDLE_Y);
    localparam logic [10:0] PAD_W11   = 11'(PADDLE_W);
    localparam logic [10:0] SERVE_OFS = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0]  SERVE_Y   = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [1:0]  LIVES0    = 2'(START_LIVES);

    state_t     state, state_nx;
    logic       dx, dy, hit_latch, launch_q;
    logic       dx_nx, dy_nx, hit_nx;
    logic [9:0] ball_x_nx, ball_y_nx, clr_x_nx, clr_y_nx;
    logic       clr_nx;
    logic [1:0] lives_nx;

    logic        launch_rise;
    logic [10:0] x_w, y_w, pad_w;
    logic        flip_x, flip_y, paddle_contact, ball_lost;

    assign launch_rise = launch & ~launch_q;
    assign x_w   = {1'b0, ball_x};
    assign y_w   = {1'b0, ball_y};
    assign pad_w = {1'b0, paddle_x};

    // Probe is the leading-corner pixel of the next step; a ball flush
    // against the left/top edge probes pixel 0 instead of wrapping.
    assign probe_x = dx ? 10'(x_w + BALL11) : ((ball_x == 10'd0) ? 10'd0 : ball_x - 10'd1);
    assign probe_y = dy ? 10'(y_w + BALL11) : ((ball_y == 10'd0) ? 10'd0 : ball_y - 10'd1);

    assign paddle_contact = dy && (y_w + BALL11 == PAD_Y11)
                            && (x_w + BALL11 > pad_w) && (x_w < pad_w + PAD_W11);
    assign flip_x    = dx ? (x_w + BALL11 >= SCR_W11) : (ball_x == 10'd0);
    assign flip_y    = (!dy && ball_y == 10'd0) || hit_latch || paddle_contact;
    assign ball_lost = dy && (y_w + BALL11 >= SCR_H11);

    assign game_over = (state == ST_DEAD);

    // Next-state and next-register computation for the whole engine.
    always_comb begin
        state_nx  = state;
        lives_nx  = lives;
        ball_x_nx = ball_x;
        ball_y_nx = ball_y;
        dx_nx     = dx;
        dy_nx     = dy;
        hit_nx    = hit_latch;
        clr_nx    = 1'b0;
        clr_x_nx  = brick_clr_x;
        clr_y_nx  = brick_clr_y;

        case (state)
            ST_SERVE: begin
                ball_x_nx = 10'(pad_w + SERVE_OFS);
                ball_y_nx = SERVE_Y;
                dx_nx     = 1'b1;
                dy_nx     = 1'b0;
                hit_nx    = 1'b0;
                if (launch_rise) begin
                    state_nx = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Direction uses the pre-edge hit latch; a hit sampled in the
                // same cycle is kept for the following dir_update.
                if (dir_update) begin
                    hit_nx = 1'b0;
                    if (ball_lost) begin
                        lives_nx = lives - 2'd1;
                        state_nx = (lives == 2'd1) ? ST_DEAD : ST_SERVE;
                    end else begin
                        if (flip_x) dx_nx = ~dx;
                        if (flip_y) dy_nx = ~dy;
                    end
                end
                if (brck_update && brick_hit) begin
                    hit_nx   = 1'b1;
                    clr_nx   = 1'b1;
                    clr_x_nx = probe_x;
                    clr_y_nx = probe_y;
                end
                if (pos_update) begin
                    ball_x_nx = dx ? ball_x + 10'd1 : ball_x - 10'd1;
                    ball_y_nx = dy ? ball_y + 10'd1 : ball_y - 10'd1;
                end
            end
            ST_DEAD: begin
                if (launch_rise) begin
                    lives_nx = LIVES0;
                    state_nx = ST_SERVE;
                end
            end
            default: begin
                state_nx = ST_SERVE;
            end
        endcase
    end

    // Register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_SERVE;
            lives       <= LIVES0;
            ball_x      <= 10'd0;
            ball_y      <= 10'd0;
            dx          <= 1'b1;
            dy          <= 1'b0;
            hit_latch   <= 1'b0;
            launch_q    <= 1'b0;
            brick_clr   <= 1'b0;
            brick_clr_x <= 10'd0;
            brick_clr_y <= 10'd0;
        end else begin
            state       <= state_nx;
            lives       <= lives_nx;
            ball_x      <= ball_x_nx;
            ball_y      <= ball_y_nx;
            dx          <= dx_nx;
            dy          <= dy_nx;
            hit_latch   <= hit_nx;
            launch_q    <= launch;
            brick_clr   <= clr_nx;
            brick_clr_x <= clr_x_nx;
            brick_clr_y <= clr_y_nx;
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl with a per-cycle reference model.
module tb_ball_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, brck_update, dir_update, pos_update, launch, brick_hit;
    logic [9:0] paddle_x;
    logic [9:0] probe_x, probe_y, ball_x, ball_y, brick_clr_x, brick_clr_y;
    logic       brick_clr, game_over;
    logic [1:0] lives;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    localparam int M_SERVE = 0, M_PLAY = 1, M_DEAD = 2;
    int m_mode, m_x, m_y, m_dx, m_dy, m_hit, m_lives, m_clr, m_clrx, m_clry, m_lprev;

    ball_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .brck_update(brck_update), .dir_update(dir_update),
        .pos_update(pos_update), .launch(launch), .paddle_x(paddle_x), .brick_hit(brick_hit),
        .probe_x(probe_x), .probe_y(probe_y), .ball_x(ball_x), .ball_y(ball_y),
        .brick_clr(brick_clr), .brick_clr_x(brick_clr_x), .brick_clr_y(brick_clr_y),
        .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic int probe_of(int p, int d);
        if (d != 0) return p + 8;
        return (p == 0) ? 0 : p - 1;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one clock of game rules applied to the model's state.
    task automatic model_step();
        int nx, ny, ndx, ndy, nhit, nlives, nmode, nclr, nclrx, nclry;
        bit rise, lost, side, vert;
        if (!rst_n) begin
            m_mode = M_SERVE; m_lives = 3; m_x = 0; m_y = 0; m_dx = 1; m_dy = 0;
            m_hit = 0; m_clr = 0; m_clrx = 0; m_clry = 0; m_lprev = 0;
            return;
        end
        rise = launch && (m_lprev == 0);
        nx = m_x; ny = m_y; ndx = m_dx; ndy = m_dy; nhit = m_hit;
        nlives = m_lives; nmode = m_mode; nclr = 0; nclrx = m_clrx; nclry = m_clry;
        if (m_mode == M_SERVE) begin
            nx = (int'(paddle_x) + 32 - 4) % 1024;
            ny = 440 - 8;
            ndx = 1; ndy = 0; nhit = 0;
            if (rise) nmode = M_PLAY;
        end else if (m_mode == M_PLAY) begin
            if (dir_update) begin
                lost = (m_dy != 0) && (m_y + 8 >= 480);
                side = (m_dx != 0) ? (m_x + 8 >= 640) : (m_x == 0);
                vert = ((m_dy == 0) && (m_y == 0)) || (m_hit != 0) ||
                       ((m_dy != 0) && (m_y + 8 == 440) && (m_x + 8 > int'(paddle_x))
                        && (m_x < int'(paddle_x) + 64));
                nhit = 0;
                if (lost) begin
                    nlives = m_lives - 1;
                    nmode  = (nlives == 0) ? M_DEAD : M_SERVE;
                end else begin
                    if (side) ndx = 1 - m_dx;
                    if (vert) ndy = 1 - m_dy;
                end
            end
            if (brck_update && brick_hit) begin
                nhit = 1; nclr = 1;
                nclrx = probe_of(m_x, m_dx);
                nclry = probe_of(m_y, m_dy);
            end
            if (pos_update) begin
                nx = m_x + ((m_dx != 0) ? 1 : -1);
                ny = m_y + ((m_dy != 0) ? 1 : -1);
            end
        end else if (rise) begin
            nlives = 3; nmode = M_SERVE;
        end
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy; m_hit = nhit; m_lives = nlives;
        m_mode = nmode; m_clr = nclr; m_clrx = nclrx; m_clry = nclry;
        m_lprev = launch ? 1 : 0;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ball_x", int'(ball_x), m_x);
            check("ball_y", int'(ball_y), m_y);
            check("probe_x", int'(probe_x), probe_of(m_x, m_dx));
            check("probe_y", int'(probe_y), probe_of(m_y, m_dy));
            check("brick_clr", int'(brick_clr), m_clr);
            check("brick_clr_x", int'(brick_clr_x), m_clrx);
            check("brick_clr_y", int'(brick_clr_y), m_clry);
            check("lives", int'(lives), m_lives);
            check("game_over", int'(game_over), (m_mode == M_DEAD) ? 1 : 0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic strobe(bit b, bit d, bit p, bit h);
        brck_update = b; dir_update = d; pos_update = p; brick_hit = h;
        cyc();
        brck_update = 0; dir_update = 0; pos_update = 0; brick_hit = 0;
    endtask

    task automatic triplet();
        strobe(1, 0, 0, 0);
        strobe(0, 1, 0, 0);
        strobe(0, 0, 1, 0);
    endtask

    task automatic play_until_loss(string name);
        int start_lives;
        int n;
        start_lives = m_lives;
        n = 0;
        while (m_lives == start_lives && n < 3000) begin
            triplet();
            n++;
        end
        check({name, "_bound"}, (n < 3000) ? 1 : 0, 1);
    endtask

    task automatic launch_edge();
        launch = 0; cyc();
        launch = 1; cyc();
    endtask

    initial begin
        rst_n = 0; brck_update = 0; dir_update = 0; pos_update = 0;
        launch = 0; brick_hit = 0; paddle_x = 10'd288;

        cyc();
        chk_en = 1'b1;
        cyc();
        check("rst_ball_x", int'(ball_x), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_clr", int'(brick_clr), 0);
        check("rst_game_over", int'(game_over), 0);

        rst_n = 1; cyc();
        check("serve_x", int'(ball_x), 316);
        check("serve_y", int'(ball_y), 432);
        paddle_x = 10'd100; cyc();
        check("serve_track_x", int'(ball_x), 128);
        paddle_x = 10'd288; cyc();

        launch = 1; cyc();
        repeat (316) triplet();
        check("right_wall_x", int'(ball_x), 632);
        check("right_wall_y", int'(ball_y), 116);
        triplet();
        check("bounce_x", int'(ball_x), 631);
        check("bounce_y", int'(ball_y), 115);
        check("bounce_probe_x", int'(probe_x), 630);

        strobe(1, 0, 0, 1);
        check("hit_clr", int'(brick_clr), 1);
        check("hit_clr_x", int'(brick_clr_x), 630);
        check("hit_clr_y", int'(brick_clr_y), 114);
        strobe(0, 1, 0, 0);
        check("hit_clr_drop", int'(brick_clr), 0);
        check("hit_dy_probe", int'(probe_y), 123);
        strobe(0, 0, 1, 0);
        check("hit_pos_x", int'(ball_x), 630);
        check("hit_pos_y", int'(ball_y), 116);

        paddle_x = 10'd290;
        repeat (316) triplet();
        check("paddle_reach_x", int'(ball_x), 314);
        check("paddle_reach_y", int'(ball_y), 432);
        triplet();
        check("paddle_bounce_x", int'(ball_x), 313);
        check("paddle_bounce_y", int'(ball_y), 431);
        check("paddle_lives", int'(lives), 3);

        paddle_x = 10'd0;
        play_until_loss("loss1");
        check("loss1_lives", int'(lives), 2);
        check("loss1_x", int'(ball_x), 28);
        check("loss1_y", int'(ball_y), 432);

        launch_edge();
        play_until_loss("loss2");
        check("loss2_lives", int'(lives), 1);

        launch_edge();
        play_until_loss("loss3");
        check("dead_lives", int'(lives), 0);
        check("dead_game_over", int'(game_over), 1);
        check("dead_x", int'(ball_x), 332);
        check("dead_y", int'(ball_y), 472);
        repeat (3) triplet();
        check("dead_frozen_x", int'(ball_x), 332);
        check("dead_frozen_y", int'(ball_y), 472);

        launch = 0; cyc();
        launch = 1; strobe(0, 0, 1, 0);
        check("restart_lives", int'(lives), 3);
        check("restart_game_over", int'(game_over), 0);
        check("restart_frozen_y", int'(ball_y), 472);
        cyc();
        check("restart_serve_x", int'(ball_x), 28);
        triplet();
        check("restart_ignores_y", int'(ball_y), 432);

        launch = 0; cyc();
        launch = 1; strobe(0, 0, 1, 0);
        check("launch_strobe_x", int'(ball_x), 28);
        check("launch_strobe_y", int'(ball_y), 432);
        triplet();
        check("play2_x", int'(ball_x), 29);
        check("play2_y", int'(ball_y), 431);

        strobe(1, 1, 1, 1);
        check("simul_clr", int'(brick_clr), 1);
        check("simul_clr_x", int'(brick_clr_x), 37);
        check("simul_clr_y", int'(brick_clr_y), 430);
        check("simul_pos_y", int'(ball_y), 430);
        strobe(0, 1, 0, 0);
        strobe(0, 0, 1, 0);
        check("simul_latched_y", int'(ball_y), 431);

        rst_n = 0; strobe(1, 0, 0, 1);
        check("rst_drop_clr", int'(brick_clr), 0);
        check("rst_mid_x", int'(ball_x), 0);
        rst_n = 1; cyc();
        check("rst_mid_serve_x", int'(ball_x), 28);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
